// File: rtl/bus_gen_arbiter_if.sv
// Bundle of device-side FIFO signals for bus_gen_arbiter.
// master: arbiter view (reads pending/head data, drives pop/push/bus data).
// slave : device FIFO view.
interface bus_gen_arbiter_if #(
  parameter int bits    = 1,
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  logic [bits-1:0][drvrs-1:0]              pndng;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [bits-1:0][drvrs-1:0]              pop;
  logic [bits-1:0][drvrs-1:0]              push;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );
endinterface

// File: rtl/bus_gen_arbiter.sv
// Shared-bus generator and arbiter. Each of the 'bits' buses runs its own
// IDLE -> POP -> PUSH loop: a round-robin winner is popped, its packet is
// latched onto the bus register, then delivered to the device named in the
// top 8 bits of the packet (or to every device on broadcast).
// Optional build macro: BUS_BCAST_SELF_EN -- broadcast also delivers back to
// the source device; without it the source is excluded.
module bus_gen_arbiter #(
  parameter int          bits      = 1,
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic              clock,
  input  logic              reset,
  bus_gen_arbiter_if.master arbIf
);

  localparam int IDW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_e;

  for (genvar b = 0; b < bits; b++) begin : gBus
    state_e             state_q, state_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [IDW-1:0]     win_q, win_d;
    logic [IDW-1:0]     cand;
    logic [IDW-1:0]     idx;
    logic               found;
    logic [7:0]         destId;
    logic [pckg_sz-1:0] bus_q, bus_d;
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;

    // Round-robin search: first pending device after the last winner, wrapping.
    always_comb begin
      found = 1'b0;
      cand  = '0;
      idx   = '0;
      for (int k = 1; k <= drvrs; k++) begin
        idx = IDW'((int'(last_q) + k) % drvrs);
        if (!found && arbIf.pndng[b][idx]) begin
          found = 1'b1;
          cand  = idx;
        end
      end
    end

    // Next-state and registered-output decode for the transfer loop.
    always_comb begin
      state_d = state_q;
      last_d  = last_q;
      win_d   = win_q;
      bus_d   = bus_q;
      pop_d   = '0;
      push_d  = '0;
      destId  = '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            state_d     = POP;
            win_d       = cand;
            pop_d[cand] = 1'b1;
          end
        end
        POP: begin
          bus_d   = arbIf.D_pop[b][win_q];
          last_d  = win_q;
          state_d = PUSH;
          destId  = arbIf.D_pop[b][win_q][pckg_sz-1 -: 8];
          if (destId == broadcast) begin
            push_d = '1;
`ifdef BUS_BCAST_SELF_EN
`else
            push_d[win_q] = 1'b0;
`endif
          end else if (int'({24'd0, destId}) < drvrs) begin
            push_d[destId[IDW-1:0]] = 1'b1;
          end
        end
        PUSH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // State and output registers; reset gives device 0 first priority.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= IDLE;
        last_q  <= IDW'(drvrs - 1);
        win_q   <= '0;
        bus_q   <= '0;
        pop_q   <= '0;
        push_q  <= '0;
      end else begin
        state_q <= state_d;
        last_q  <= last_d;
        win_q   <= win_d;
        bus_q   <= bus_d;
        pop_q   <= pop_d;
        push_q  <= push_d;
      end
    end

    assign arbIf.pop[b]    = pop_q;
    assign arbIf.push[b]   = push_q;
    assign arbIf.D_push[b] = {drvrs{bus_q}};
  end

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Testbench for bus_gen_arbiter (one bus, four devices, 16-bit packets).
// Device FIFOs are modelled with queues; a transaction-level model predicts
// the pop order and delivery of every loaded packet, and a monitor compares
// those predictions against pop/push/D_push as they appear.
// Honours BUS_BCAST_SELF_EN when the design is built with it.
module tb_bus_gen_arbiter;
  localparam int DRVRS = 4;
  localparam int PSZ   = 16;
`ifdef BUS_BCAST_SELF_EN
  localparam bit SELF_BCAST = 1'b1;
`else
  localparam bit SELF_BCAST = 1'b0;
`endif

  typedef struct {
    int          dev;
    logic [3:0]  mask;
    logic [15:0] data;
  } xfer_t;

  logic clock;
  logic reset;

  bus_gen_arbiter_if #(.bits(1), .drvrs(DRVRS), .pckg_sz(PSZ)) busIf ();

  bus_gen_arbiter #(
    .bits(1), .drvrs(DRVRS), .pckg_sz(PSZ), .broadcast(8'hFF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .arbIf (busIf)
  );

  logic [15:0] devQ   [DRVRS][$];
  logic [15:0] stageQ [DRVRS][$];
  xfer_t       expQ[$];
  xfer_t       curXfer;
  bit          pendXfer;
  bit          monEnable;
  int          testsRun;
  int          testsFailed;
  int          cycle;
  int          phaseId;
  int          lastPopCyc;
  int          lastPopPhase;
  int          mLast;
  logic [15:0] lastData;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device FIFO model: dequeue on a sampled pop, present head and pending flag.
  initial begin
    logic [3:0] popSeen;
    busIf.pndng = '0;
    busIf.D_pop = '0;
    forever begin
      @(negedge clock);
      popSeen = busIf.pop[0];
      @(posedge clock);
      #1;
      for (int i = 0; i < DRVRS; i++) begin
        if (popSeen[i] && devQ[i].size() > 0) devQ[i].delete(0);
        busIf.pndng[0][i] = (devQ[i].size() > 0);
        busIf.D_pop[0][i] = (devQ[i].size() > 0) ? devQ[i][0] : 16'h0000;
      end
    end
  end

  // Monitor: consume one expected transfer per pop, check delivery next cycle.
  initial begin
    pendXfer     = 1'b0;
    lastPopCyc   = 0;
    lastPopPhase = -1;
    forever begin
      @(negedge clock);
      cycle++;
      if (monEnable && !reset) begin
        if (pendXfer) begin
          checkOutput("pushMask", 64'(busIf.push[0]), 64'(curXfer.mask));
          checkOutput("dPush", busIf.D_push[0], {4{curXfer.data}});
          pendXfer = 1'b0;
        end else begin
          checkOutput("pushIdle", 64'(busIf.push[0]), 64'd0);
        end
        if (busIf.pop[0] != 4'b0000) begin
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedPop: got pop=%b expected none", busIf.pop[0]);
          end else begin
            curXfer = expQ.pop_front();
            checkOutput("popDev", 64'(busIf.pop[0]), 64'(4'b0001 << curXfer.dev));
            if (lastPopPhase == phaseId)
              checkOutput("popGap", 64'(cycle - lastPopCyc), 64'd3);
            lastPopCyc   = cycle;
            lastPopPhase = phaseId;
            pendXfer     = 1'b1;
          end
        end
      end else begin
        pendXfer = 1'b0;
      end
    end
  end

  // Load staged packets into the device FIFOs, predict transfers, wait for drain.
  task automatic applyStimulus();
    logic [15:0] mq [DRVRS][$];
    logic [15:0] pkt;
    logic [3:0]  m;
    xfer_t       x;
    int          remaining;
    int          d;
    int          c;
    int          n;
    @(negedge clock);
    phaseId++;
    remaining = 0;
    for (int i = 0; i < DRVRS; i++) begin
      mq[i]     = stageQ[i];
      remaining += stageQ[i].size();
    end
    n = remaining;
    while (remaining > 0) begin
      d = -1;
      for (int k = 1; k <= DRVRS; k++) begin
        c = (mLast + k) % DRVRS;
        if (d < 0 && mq[c].size() > 0) d = c;
      end
      pkt = mq[d].pop_front();
      if (pkt[15:8] == 8'hFF)
        m = SELF_BCAST ? 4'hF : (4'hF ^ (4'b0001 << d));
      else if (int'(pkt[15:8]) < DRVRS)
        m = 4'b0001 << pkt[15:8];
      else
        m = 4'b0000;
      x.dev  = d;
      x.mask = m;
      x.data = pkt;
      expQ.push_back(x);
      mLast    = d;
      lastData = pkt;
      remaining--;
    end
    for (int i = 0; i < DRVRS; i++) begin
      devQ[i] = stageQ[i];
      stageQ[i].delete();
    end
    for (int t = 0; t < 3 * n + 12 && (expQ.size() != 0 || pendXfer); t++)
      @(negedge clock);
    repeat (2) @(negedge clock);
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drainTimeout: got %0d transfers outstanding expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    bit          seen;
    logic [7:0]  id;
    int          r;
    testsRun    = 0;
    testsFailed = 0;
    cycle       = 0;
    phaseId     = 0;
    monEnable   = 1'b0;
    lastData    = 16'h0000;
    reset       = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("resetPop", 64'(busIf.pop[0]), 64'd0);
    checkOutput("resetPush", 64'(busIf.push[0]), 64'd0);
    checkOutput("resetDPush", busIf.D_push[0], 64'd0);
    reset     = 1'b0;
    mLast     = DRVRS - 1;
    monEnable = 1'b1;

    // point-to-point
    stageQ[0].push_back(16'h02AB);
    applyStimulus();

    // round robin over devices 1..3
    for (int i = 1; i < DRVRS; i++)
      for (int j = 0; j < 3; j++)
        stageQ[i].push_back({8'(j % DRVRS), 8'($urandom_range(0, 255))});
    applyStimulus();

    // broadcast from device 3
    stageQ[3].push_back(16'hFF55);
    applyStimulus();

    // invalid destination
    stageQ[1].push_back(16'h0712);
    applyStimulus();

    // reset during the POP cycle
    monEnable = 1'b0;
    @(negedge clock);
    devQ[1].push_back(16'h0133);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clock);
      if (busIf.pop[0][1]) seen = 1'b1;
    end
    checkOutput("rstPopSeen", 64'(seen), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rstMidPop", 64'(busIf.pop[0]), 64'd0);
    checkOutput("rstMidPush", 64'(busIf.push[0]), 64'd0);
    checkOutput("rstMidDPush", busIf.D_push[0], 64'd0);
    reset = 1'b0;
    mLast = DRVRS - 1;
    @(negedge clock);
    monEnable = 1'b1;
    stageQ[0].push_back(16'h0322);
    stageQ[3].push_back(16'h0044);
    applyStimulus();

    // randomized mixes of valid, broadcast and invalid destinations
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < DRVRS; i++) begin
        for (int j = $urandom_range(0, 3); j > 0; j--) begin
          r = $urandom_range(0, 9);
          if (r < 6)      id = 8'($urandom_range(0, DRVRS - 1));
          else if (r < 8) id = 8'hFF;
          else            id = 8'($urandom_range(DRVRS, 254));
          stageQ[i].push_back({id, 8'($urandom_range(0, 255))});
        end
      end
      applyStimulus();
    end

    // idle bus holds the last bus value
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      checkOutput("idlePop", 64'(busIf.pop[0]), 64'd0);
      checkOutput("idleDPush", busIf.D_push[0], {4{lastData}});
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
